// File: rtl/spi_aes_pkg.sv
// Shared definitions for the SPI-to-AES receive sequencer.
//   BLOCK_W            : width of one AES block in bits
//   START_CYCLES_DEF   : default number of cycles dec_start is held per launch
//   TIMEOUT_CYCLES_DEF : default number of cycles to wait for dec_done before abort
//   state_e            : sequencer FSM states
package spi_aes_pkg;

  localparam int unsigned BLOCK_W            = 128;
  localparam int unsigned START_CYCLES_DEF   = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitDone,
    StHold,
    StAbort
  } state_e;

endpackage

// File: rtl/block_fifo.sv
// Synchronous first-word-fall-through FIFO of BLOCK_W-wide entries.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (empties the FIFO)
//   push_i  : write wdata_i; ignored when full unless a pop happens on the same edge
//   wdata_i : write data
//   pop_i   : discard the head entry; ignored when empty
//   rdata_o : head entry, valid whenever empty_o is low
//   full_o  : Depth entries stored
//   empty_o : no entries stored
module block_fifo
  import spi_aes_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [BLOCK_W-1:0] wdata_i,
  input  logic               pop_i,
  output logic [BLOCK_W-1:0] rdata_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);

  logic [BLOCK_W-1:0] mem_q [Depth];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(Depth - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // When full, a same-edge pop frees the head slot, which is exactly where wr_ptr points,
  // so the write lands in the slot being vacated.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/spi_aes_rx_sequencer.sv
// Sequencer between the SPI slave receiver and the AES-128 decryption core.
// Buffers ciphertext blocks, launches one decryption per block, and presents each
// plaintext on a valid/ready output.
//   clk, resetn            : clock, asynchronous active-low reset
//   rx_data, rx_valid      : ciphertext block from SPI, one-cycle valid pulse
//   dec_ciphertext         : block presented to the core
//   dec_start              : core decrypt request, held START_CYCLES cycles
//   dec_done, dec_plaintext: core completion level and result
//   dec_abort              : one-cycle pulse when the core times out
//   pt_data, pt_valid,
//   pt_ready               : plaintext output handshake
//   busy                   : FSM active or FIFO not empty
//   overflow, timeout      : sticky error flags, cleared by clear_err
//   block_count            : plaintexts accepted on the output (wraps)
module spi_aes_rx_sequencer
  import spi_aes_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned START_CYCLES   = START_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [BLOCK_W-1:0] rx_data,
  input  logic               rx_valid,
  output logic [BLOCK_W-1:0] dec_ciphertext,
  output logic               dec_start,
  input  logic               dec_done,
  input  logic [BLOCK_W-1:0] dec_plaintext,
  output logic               dec_abort,
  output logic [BLOCK_W-1:0] pt_data,
  output logic               pt_valid,
  input  logic               pt_ready,
  output logic               busy,
  output logic               overflow,
  output logic               timeout,
  input  logic               clear_err,
  output logic [15:0]        block_count
);

  state_e             state_q, state_d;
  logic [3:0]         start_cnt_q, start_cnt_d;
  logic [15:0]        tmo_cnt_q, tmo_cnt_d;
  logic               dec_done_q;
  logic [BLOCK_W-1:0] dec_ct_q, dec_ct_d;
  logic               dec_start_q, dec_start_d;
  logic               dec_abort_q, dec_abort_d;
  logic [BLOCK_W-1:0] pt_data_q, pt_data_d;
  logic               pt_valid_q, pt_valid_d;
  logic               overflow_q, overflow_d;
  logic               timeout_q, timeout_d;
  logic [15:0]        block_count_q, block_count_d;

  logic [BLOCK_W-1:0] fifo_rdata;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic               done_rise, tmo_hit, start_last, handshake, drop;
  logic [15:0]        tmo_inc;

  block_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (rx_valid),
    .wdata_i (rx_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A done level left high from the previous operation never forms an edge here,
  // so it is ignored until it has dropped and risen again.
  assign done_rise  = dec_done && !dec_done_q;
  assign tmo_hit    = (tmo_cnt_q >= 16'(TIMEOUT_CYCLES));
  assign start_last = (start_cnt_q == 4'(START_CYCLES));
  assign handshake  = pt_valid_q && pt_ready;
  assign tmo_inc    = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
  assign drop       = rx_valid && fifo_full && !fifo_pop;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (!fifo_empty) state_d = StLoad;
      StLoad:     if (start_last) state_d = StWaitDone;
      StWaitDone: begin
        if (done_rise) begin
          state_d = StHold;
        end else if (tmo_hit) begin
          state_d = StAbort;
        end
      end
      StHold:     if (handshake) state_d = StIdle;
      StAbort:    state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Output and datapath next values; outputs are registered.
  always_comb begin
    fifo_pop      = 1'b0;
    dec_ct_d      = dec_ct_q;
    dec_start_d   = 1'b0;
    dec_abort_d   = 1'b0;
    pt_data_d     = pt_data_q;
    pt_valid_d    = pt_valid_q;
    start_cnt_d   = start_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    block_count_d = block_count_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          dec_ct_d    = fifo_rdata;
          dec_start_d = 1'b1;
          start_cnt_d = 4'd1;
          tmo_cnt_d   = '0;
        end
      end
      StLoad: begin
        tmo_cnt_d = tmo_inc;
        if (!start_last) begin
          dec_start_d = 1'b1;
          start_cnt_d = start_cnt_q + 4'd1;
        end
      end
      StWaitDone: begin
        tmo_cnt_d = tmo_inc;
        if (done_rise) begin
          pt_data_d  = dec_plaintext;
          pt_valid_d = 1'b1;
        end else if (tmo_hit) begin
          dec_abort_d = 1'b1;
        end
      end
      StHold: begin
        if (handshake) begin
          pt_valid_d    = 1'b0;
          block_count_d = block_count_q + 16'd1;
        end
      end
      StAbort: begin
      end
      default: begin
      end
    endcase

    // A set on the same edge wins over clear_err.
    overflow_d = drop ? 1'b1 : (clear_err ? 1'b0 : overflow_q);
    timeout_d  = dec_abort_d ? 1'b1 : (clear_err ? 1'b0 : timeout_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_cnt_q   <= '0;
      tmo_cnt_q     <= '0;
      dec_done_q    <= 1'b0;
      dec_ct_q      <= '0;
      dec_start_q   <= 1'b0;
      dec_abort_q   <= 1'b0;
      pt_data_q     <= '0;
      pt_valid_q    <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_q     <= 1'b0;
      block_count_q <= '0;
    end else begin
      start_cnt_q   <= start_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      dec_done_q    <= dec_done;
      dec_ct_q      <= dec_ct_d;
      dec_start_q   <= dec_start_d;
      dec_abort_q   <= dec_abort_d;
      pt_data_q     <= pt_data_d;
      pt_valid_q    <= pt_valid_d;
      overflow_q    <= overflow_d;
      timeout_q     <= timeout_d;
      block_count_q <= block_count_d;
    end
  end

  assign dec_ciphertext = dec_ct_q;
  assign dec_start      = dec_start_q;
  assign dec_abort      = dec_abort_q;
  assign pt_data        = pt_data_q;
  assign pt_valid       = pt_valid_q;
  assign overflow       = overflow_q;
  assign timeout        = timeout_q;
  assign block_count    = block_count_q;
  assign busy           = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_spi_aes_rx_sequencer.sv
// Bench for spi_aes_rx_sequencer: directed scenarios plus a randomized phase checked
// against a block-level reference model (capacity FIFO_DEPTH+1 blocks in flight).
module tb_spi_aes_rx_sequencer;

  localparam int unsigned Depth = 2;
  localparam logic [127:0] Ct1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Pt1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Ct2 = 128'h1b872378795f4ffd772855fc87ca964d;
  localparam logic [127:0] Pt2 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] Mask = 128'h5a3c_96e1_0f1e_2d3c_4b5a_6978_8796_a5b4;

  logic         clk = 1'b0;
  logic         resetn;
  logic [127:0] rx_data;
  logic         rx_valid;
  logic [127:0] dec_ciphertext;
  logic         dec_start;
  logic         dec_done;
  logic [127:0] dec_plaintext;
  logic         dec_abort;
  logic [127:0] pt_data;
  logic         pt_valid;
  logic         pt_ready;
  logic         busy;
  logic         overflow;
  logic         timeout;
  logic         clear_err;
  logic [15:0]  block_count;

  always #5 clk = ~clk;

  spi_aes_rx_sequencer #(
    .FIFO_DEPTH     (Depth),
    .START_CYCLES   (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .dec_ciphertext (dec_ciphertext),
    .dec_start      (dec_start),
    .dec_done       (dec_done),
    .dec_plaintext  (dec_plaintext),
    .dec_abort      (dec_abort),
    .pt_data        (pt_data),
    .pt_valid       (pt_valid),
    .pt_ready       (pt_ready),
    .busy           (busy),
    .overflow       (overflow),
    .timeout        (timeout),
    .clear_err      (clear_err),
    .block_count    (block_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Stand-in for the AES core: the two known vectors, anything else XOR a mask.
  function automatic logic [127:0] core_fn(input logic [127:0] ct);
    if (ct == Ct1) return Pt1;
    if (ct == Ct2) return Pt2;
    return ct ^ Mask;
  endfunction

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- core model ----------------
  // mode 0: normal (done drops at start, rises after latency)
  // mode 1: never completes
  // mode 2: done left high through start, dips low one cycle, then rises
  int           core_mode = 0;
  int           core_lat  = 0;
  bit           core_busy;
  int           core_cnt;
  logic [127:0] core_ct;

  initial begin
    dec_done = 1'b0;
    dec_plaintext = '0;
    core_busy = 1'b0;
    core_cnt = 0;
    core_ct = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!resetn || dec_abort) begin
        core_busy = 1'b0;
        dec_done = 1'b0;
      end else if (dec_start) begin
        if (!core_busy) begin
          core_busy = 1'b1;
          core_ct = dec_ciphertext;
          core_cnt = (core_lat != 0) ? core_lat : int'($urandom_range(1, 6));
          if (core_mode != 2) dec_done = 1'b0;
        end
      end else if (core_busy) begin
        if (core_cnt == 0) begin
          core_busy = 1'b0;
          if (core_mode != 1) begin
            dec_done = 1'b1;
            dec_plaintext = core_fn(core_ct);
          end
        end else begin
          if (core_mode == 2 && core_cnt == 1) dec_done = 1'b0;
          core_cnt--;
        end
      end
    end
  end

  // ---------------- reference model / monitor ----------------
  // A block is dropped exactly when FIFO_DEPTH+1 blocks are already in flight;
  // a block leaves flight on its output handshake or on an abort.
  int           n_inflight = 0;
  bit           exp_ovf = 1'b0;
  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];
  bit           last_hold = 1'b0;
  logic [127:0] last_pt;

  always @(negedge clk) begin
    if (!resetn) begin
      n_inflight = 0;
      exp_ovf = 1'b0;
      exp_q.delete();
      last_hold = 1'b0;
    end else begin
      if (last_hold) begin
        chk_b("pt_valid_held", pt_valid, 1'b1);
        chk_w("pt_data_held", pt_data, last_pt);
      end
      if (rx_valid && n_inflight == int'(Depth) + 1) begin
        exp_ovf = 1'b1;
      end else begin
        if (clear_err) exp_ovf = 1'b0;
        if (rx_valid) begin
          n_inflight++;
          exp_q.push_back(core_fn(rx_data));
        end
      end
      if (pt_valid && pt_ready) begin
        got_q.push_back(pt_data);
        n_inflight--;
      end
      if (dec_abort) begin
        n_inflight--;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      last_hold = pt_valid && !pt_ready;
      last_pt = pt_data;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d);
    rx_valid = 1'b1;
    rx_data = d;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while ((busy || pt_valid) && k < 400) begin
      tick();
      k++;
    end
    chk_b({tag, "_drained"}, busy | pt_valid, 1'b0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk_b({tag, "_dec_start"}, dec_start, 1'b0);
    chk_b({tag, "_dec_abort"}, dec_abort, 1'b0);
    chk_b({tag, "_pt_valid"}, pt_valid, 1'b0);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_overflow"}, overflow, 1'b0);
    chk_b({tag, "_timeout"}, timeout, 1'b0);
    chk_w({tag, "_block_count"}, 128'(block_count), 128'(16'd0));
    chk_w({tag, "_dec_ct"}, dec_ciphertext, 128'd0);
    chk_w({tag, "_pt_data"}, pt_data, 128'd0);
  endtask

  logic [127:0] blk [4];
  int           k;
  int           aborts;

  initial begin
    resetn = 1'b0;
    rx_valid = 1'b0;
    rx_data = '0;
    pt_ready = 1'b0;
    clear_err = 1'b0;
    repeat (3) tick();
    chk_zero_outputs("reset");
    resetn = 1'b1;
    tick();

    // FIPS-197 vector, with launch timing
    pt_ready = 1'b1;
    send(Ct1);
    tick();
    chk_b("fips_start_t2", dec_start, 1'b1);
    chk_w("fips_ct_t2", dec_ciphertext, Ct1);
    tick();
    chk_b("fips_start_t3", dec_start, 1'b1);
    tick();
    chk_b("fips_start_t4", dec_start, 1'b0);
    k = 0;
    while (dec_done !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk_b("fips_pt_valid_after_done", pt_valid, 1'b1);
    wait_drain("fips");
    chk_w("fips_count", 128'(got_q.size()), 128'd1);
    chk_w("fips_pt", got_q.size() > 0 ? got_q[0] : '0, Pt1);
    chk_w("fips_block_count", 128'(block_count), 128'(16'd1));

    // Back-to-back
    got_q.delete();
    send(Ct2);
    send(Ct1);
    wait_drain("b2b");
    chk_w("b2b_count", 128'(got_q.size()), 128'd2);
    chk_w("b2b_pt0", got_q.size() > 0 ? got_q[0] : '0, Pt2);
    chk_w("b2b_pt1", got_q.size() > 1 ? got_q[1] : '0, Pt1);
    chk_w("b2b_block_count", 128'(block_count), 128'(16'd3));

    // Backpressure: 4 blocks, only 3 fit
    got_q.delete();
    pt_ready = 1'b0;
    for (int i = 0; i < 4; i++) blk[i] = rand_blk();
    for (int i = 0; i < 4; i++) send(blk[i]);
    repeat (20) tick();
    chk_b("bp_overflow", overflow, 1'b1);
    chk_b("bp_pt_valid", pt_valid, 1'b1);
    chk_w("bp_pt_data", pt_data, core_fn(blk[0]));
    chk_w("bp_block_count", 128'(block_count), 128'(16'd3));
    pt_ready = 1'b1;
    wait_drain("bp");
    chk_w("bp_count", 128'(got_q.size()), 128'd3);
    for (int i = 0; i < 3; i++) begin
      chk_w($sformatf("bp_pt%0d", i), got_q.size() > i ? got_q[i] : '0, core_fn(blk[i]));
    end
    chk_b("bp_overflow_sticky", overflow, 1'b1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk_b("bp_overflow_cleared", overflow, 1'b0);

    // Timeout: first block never completes, second must decrypt
    got_q.delete();
    core_mode = 1;
    blk[0] = rand_blk();
    blk[1] = rand_blk();
    send(blk[0]);
    send(blk[1]);
    k = 0;
    while (dec_abort !== 1'b1 && k < 80) begin
      tick();
      k++;
    end
    chk_b("to_abort_seen", dec_abort, 1'b1);
    chk_b("to_flag", timeout, 1'b1);
    core_mode = 0;
    aborts = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dec_abort === 1'b1) aborts++;
    end
    chk_w("to_abort_pulses", 128'(aborts), 128'd1);
    wait_drain("to");
    chk_w("to_count", 128'(got_q.size()), 128'd1);
    chk_w("to_next_pt", got_q.size() > 0 ? got_q[0] : '0, core_fn(blk[1]));
    chk_b("to_flag_sticky", timeout, 1'b1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk_b("to_flag_cleared", timeout, 1'b0);

    // Stale done: done is high from the previous block and stays high across LOAD
    got_q.delete();
    core_mode = 2;
    core_lat = 5;
    blk[2] = rand_blk();
    send(blk[2]);
    k = 0;
    while (dec_start !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    while (dec_start === 1'b1 && k < 40) begin
      tick();
      k++;
    end
    for (int i = 0; i < 3; i++) begin
      chk_b($sformatf("stale_no_pt_valid%0d", i), pt_valid, 1'b0);
      tick();
    end
    wait_drain("stale");
    chk_w("stale_count", 128'(got_q.size()), 128'd1);
    chk_w("stale_pt", got_q.size() > 0 ? got_q[0] : '0, core_fn(blk[2]));
    core_mode = 0;
    core_lat = 0;

    // Reset in WAIT_DONE
    core_lat = 6;
    send(Ct1);
    k = 0;
    while (dec_start !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    while (dec_start === 1'b1 && k < 40) begin
      tick();
      k++;
    end
    tick();
    resetn = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    tick();
    tick();
    resetn = 1'b1;
    got_q.delete();
    core_lat = 0;
    tick();
    send(Ct1);
    wait_drain("postrst");
    chk_w("postrst_count", 128'(got_q.size()), 128'd1);
    chk_w("postrst_pt", got_q.size() > 0 ? got_q[0] : '0, Pt1);
    chk_w("postrst_block_count", 128'(block_count), 128'(16'd1));

    // Randomized traffic against the block-level model
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data = rand_blk();
      pt_ready = $urandom_range(0, 1) == 1;
      clear_err = ($urandom_range(0, 15) == 0);
      tick();
    end
    rx_valid = 1'b0;
    clear_err = 1'b0;
    pt_ready = 1'b1;
    wait_drain("rand");
    chk_w("rand_count", 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_w($sformatf("rand_pt%0d", i), got_q.size() > i ? got_q[i] : '0, exp_q[i]);
    end
    chk_b("rand_overflow", overflow, exp_ovf);
    chk_b("rand_timeout", timeout, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_aes_rx_sequencer.md
# spi_aes_rx_sequencer

Controller between the 8-lane SPI slave receiver and the AES-128 decryption core. Buffers 128-bit ciphertext blocks delivered by single-cycle `rx_valid` pulses and launches one decryption per block. Holds each plaintext result on a valid/ready output until the consumer takes it. Replaces the hand-sequenced capture/start/wait logic in the bench, so the SPI→decrypt path runs unattended in the SoC.

## Interface
- `FIFO_DEPTH`, 2: ciphertext blocks buffered ahead of the core. Power of two, ≥1.
- `START_CYCLES`, 2: cycles `dec_start` is held high per launch. Range 1–15.
- `TIMEOUT_CYCLES`, 1024: max cycles waiting for `dec_done` before abort. Range 16–65535.

Ports:
- `clk` in 1: single system clock; all logic is on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `rx_data` in 128: block from the SPI slave; valid only while `rx_valid` is high.
- `rx_valid` in 1: one-cycle pulse per received block.
- `dec_ciphertext` out 128: to core `encrypted_text_in`; stable from LOAD entry until the next LOAD.
- `dec_start` out 1: to core `decrypt`.
- `dec_done` in 1: core done; treated as a level that may stay high between operations.
- `dec_plaintext` in 128: core `Dout`.
- `dec_abort` out 1: one-cycle pulse on timeout; ORed into the core reset at top level.
- `pt_data` out 128: plaintext output.
- `pt_valid` out 1: plaintext available.
- `pt_ready` in 1: consumer accepts `pt_data`.
- `busy` out 1: FSM not IDLE, or FIFO not empty.
- `overflow` out 1: sticky; a block was dropped because the FIFO was full.
- `timeout` out 1: sticky; a decryption was aborted.
- `clear_err` in 1: synchronous clear of `overflow` and `timeout`.
- `block_count` out 16: count of plaintexts accepted on the output; wraps at 0xFFFF→0.

Reset values: all outputs 0, FIFO empty, FSM in IDLE.

## Operation
- **FIFO write.** A write occurs on every `clk` edge where `rx_valid`=1.
  - If the FIFO is full and no pop happens that edge, the block is dropped, `overflow` is set to 1, and the contents are unchanged.
  - A push and a pop on the same edge while full are legal; the push is kept.
- **FSM states:** IDLE, LOAD, WAIT_DONE, HOLD, ABORT.
- **IDLE:** if the FIFO is not empty, pop the head into `dec_ciphertext`, set `dec_start`=1, and go to LOAD.
- **LOAD:** hold `dec_start` high for `START_CYCLES` cycles total, then drive it to 0 and go to WAIT_DONE. The timeout counter is cleared on LOAD entry.
- **WAIT_DONE:**
  - On a `dec_done` rising edge (registered `dec_done_q`=0, `dec_done`=1), latch `dec_plaintext` into `pt_data`, set `pt_valid`=1, and go to HOLD.
  - A `dec_done` that is already high on LOAD entry is ignored until it has been seen low.
  - If the counter reaches `TIMEOUT_CYCLES`, go to ABORT.
- **HOLD:** on an edge where `pt_valid`=1 and `pt_ready`=1, clear `pt_valid`, increment `block_count`, and go to IDLE. `pt_data` stays unchanged while `pt_valid` is high.
- **ABORT:** pulse `dec_abort` for 1 cycle, set `timeout`=1, discard the block, and return to IDLE. No plaintext is emitted.
- **Error flags:** `clear_err` has priority below a same-cycle set, so the flag stays 1.
- **Reset mid-operation:** the FSM, FIFO, flags and counter all return to reset values immediately; an in-flight block is lost.

## Timing
- `rx_valid` in cycle t with an empty FIFO and IDLE FSM: `dec_start` is high in cycles t+2 … t+1+`START_CYCLES`, and `dec_ciphertext` is valid from t+2.
- `dec_done` rising in cycle d: `pt_valid`=1 from cycle d+1.
- With `pt_ready` tied high, back-to-back blocks are relaunched 2 cycles after the handshake edge (HOLD→IDLE→LOAD).
- Throughput limit: one block per (core latency + `START_CYCLES` + 4) cycles.

## Structure
- Package `spi_aes_pkg`: `BLOCK_W`=128, FSM state enum, `START_CYCLES`/`TIMEOUT_CYCLES` defaults.
- Sub-module `block_fifo`: synchronous FIFO of width `BLOCK_W` and depth `FIFO_DEPTH`, with push/pop/full/empty and first-word-fall-through.
- The FSM, timeout counter and output register live in the top module.

## Test plan
- **FIPS-197 vector:** SPI-deliver 69c4e0d86a7b0430d8cdb78070b4c55a with key 000102…0f and `pt_ready`=1 → one `pt_valid` with 00112233445566778899aabbccddeeff; `block_count`=1.
- **Back-to-back:** two blocks 1b872378795f4ffd772855fc87ca964d then 69c4e0d8… → plaintexts ffeeddcc…1100 then 00112233…eeff, in order.
- **Backpressure:** `pt_ready`=0 with `FIFO_DEPTH`=2 and 4 blocks sent → blocks 1–3 retained and `overflow`=1 on the 4th. After release, exactly 3 plaintexts; `clear_err` returns `overflow` to 0.
- **Timeout:** `dec_done` forced 0, `TIMEOUT_CYCLES`=16 → `dec_abort` pulses once, `timeout`=1, FSM reaches IDLE and the next queued block decrypts correctly.
- **Stale done:** `dec_done` held high across LOAD → no spurious `pt_valid` until a fresh rising edge.
- **Reset in WAIT_DONE:** deassert `resetn` mid-decrypt → all outputs 0 within the same cycle; a subsequent FIPS block still passes.
